fmap_stream_src: RTL

FMAP_STREAM_SRC -- requirements
Module: fmap_stream_src

---
 rtl/fmap_stream_src.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fmap_stream_src.sv
// Stores an IMG_Width x IMG_Height feature map and streams it row-major with row/col tags.
// First Valid_OUT comes two edges after Start; Hold pauses emission without skipping or repeating pixels.
module fmap_stream_src #(
   parameter  int IMG_Width  = 3,
   parameter  int IMG_Height = 3,
   parameter  int Datawidth  = 16,
   localparam int N          = IMG_Width * IMG_Height,
   localparam int AW         = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 CLK,
   input  logic                 CLR,
   input  logic                 WR_EN,
   input  logic [AW-1:0]        WR_ADDR,
   input  logic [Datawidth-1:0] WR_DATA,
   input  logic                 Start,
   input  logic                 Hold,
   output logic [Datawidth-1:0] Out,
   output logic                 Valid_OUT,
   output logic [Datawidth-1:0] Hang,
   output logic [Datawidth-1:0] Cot,
   output logic                 Last,
   output logic                 Busy,
   output logic                 Done
);
   localparam int RW = (IMG_Height > 1) ? $clog2(IMG_Height) : 1;
   localparam int CW = (IMG_Width > 1) ? $clog2(IMG_Width) : 1;
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_Height - 1);
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_Width - 1);
   localparam logic [AW:0]   N_L     = (AW+1)'(N);

   typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;

   state_t               state_q;
   logic [Datawidth-1:0] mem_q [N];
   logic [RW-1:0]        row_q;
   logic [CW-1:0]        col_q;
   logic [Datawidth-1:0] out_q;
   logic [Datawidth-1:0] hang_q;
   logic [Datawidth-1:0] cot_q;
   logic                 vld_q;
   logic                 last_q;
   logic                 busy_q;
   logic                 done_q;

   logic [AW-1:0]        rd_idx;
   logic [Datawidth-1:0] pixel_d;
   logic                 at_end;
   logic                 wr_ok;

   assign rd_idx  = AW'(32'(row_q) * IMG_Width + 32'(col_q));
   assign pixel_d = mem_q[rd_idx];
   assign at_end  = (row_q == ROW_MAX) && (col_q == COL_MAX);
   // Storage is only writable while idle so a running stream always sees a frozen map.
   assign wr_ok   = !CLR && WR_EN && (state_q == IDLE) && ({1'b0, WR_ADDR} < N_L);

   always_ff @(posedge CLK) begin
      if (wr_ok) begin
         mem_q[WR_ADDR] <= WR_DATA;
      end
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         out_q   <= '0;
         hang_q  <= '0;
         cot_q   <= '0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               vld_q  <= 1'b0;
               last_q <= 1'b0;
               done_q <= 1'b0;
               if (Start) begin
                  state_q <= STREAM;
                  row_q   <= '0;
                  col_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            STREAM: begin
               if (Hold) begin
                  vld_q  <= 1'b0;
                  last_q <= 1'b0;
               end else begin
                  out_q  <= pixel_d;
                  hang_q <= Datawidth'(row_q);
                  cot_q  <= Datawidth'(col_q);
                  vld_q  <= 1'b1;
                  if (at_end) begin
                     last_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= FIN;
                  end else begin
                     last_q <= 1'b0;
                     if (col_q == COL_MAX) begin
                        col_q <= '0;
                        row_q <= row_q + RW'(1);
                     end else begin
                        col_q <= col_q + CW'(1);
                     end
                  end
               end
            end
            FIN: begin
               vld_q   <= 1'b0;
               last_q  <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               row_q   <= '0;
               col_q   <= '0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign Out       = out_q;
   assign Valid_OUT = vld_q;
   assign Hang      = hang_q;
   assign Cot       = cot_q;
   assign Last      = last_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
endmodule
